// File: rtl/sobel_pkg.sv
// Shared types and elaboration-time helpers for the streaming Sobel engine.
package sobel_pkg;

  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;

  // Guard bits on top of PIX_W so a signed gradient of +/-4*(2^PIX_W-1) fits.
  localparam int GUARD_BITS = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int sum_w(input int pix_w);
    return pix_w + GUARD_BITS;
  endfunction

  function automatic int sat_max(input int pix_w);
    return (1 << pix_w) - 1;
  endfunction

endpackage

// File: rtl/sobel_stream_engine_kernel.sv
// Combinational 3x3 Sobel: |Gx|+|Gy| saturated to PIX_W bits.
// With SOBEL_THRESH_EN defined the result is binarised against THRESH.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int THRESH = 128
) (
  input  logic [PIX_W-1:0] p0_i,
  input  logic [PIX_W-1:0] p1_i,
  input  logic [PIX_W-1:0] p2_i,
  input  logic [PIX_W-1:0] p3_i,
  input  logic [PIX_W-1:0] p5_i,
  input  logic [PIX_W-1:0] p6_i,
  input  logic [PIX_W-1:0] p7_i,
  input  logic [PIX_W-1:0] p8_i,
  output logic [PIX_W-1:0] mag_o
);
  localparam int SW = sum_w(PIX_W);

  logic signed [SW-1:0] gx, gy;
  logic        [SW-1:0] ax, ay, sum;
  logic     [PIX_W-1:0] sat;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{GUARD_BITS{1'b0}}, p});
  endfunction

  always_comb begin
    gx  = (ext(p2_i) + (ext(p5_i) <<< 1) + ext(p8_i)) - (ext(p0_i) + (ext(p3_i) <<< 1) + ext(p6_i));
    gy  = (ext(p6_i) + (ext(p7_i) <<< 1) + ext(p8_i)) - (ext(p0_i) + (ext(p1_i) <<< 1) + ext(p2_i));
    ax  = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    sum = ax + ay;
    sat = (sum > SW'(sat_max(PIX_W))) ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
    mag_o = (sat >= PIX_W'(THRESH)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
    mag_o = sat;
`endif
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine with ready/valid on both sides, SOF resync
// and end-of-frame pulse. Define SOBEL_THRESH_EN for binarised output.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int PIX_W  = 8,
  parameter int THRESH = 128
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [PIX_W-1:0]                       in_data,
  input  logic                                   in_val,
  input  logic                                   in_sof,
  output logic                                   in_rdy,
  output logic [PIX_W-1:0]                       out_data,
  output logic [clog2((IMG_W-2)*(IMG_H-2))-1:0]  out_addr,
  output logic                                   out_val,
  input  logic                                   out_rdy,
  output logic                                   frame_done
);
  localparam int AW = clog2((IMG_W-2)*(IMG_H-2));
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    sel_q, sel_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [PIX_W-1:0]        ram0_q [IMG_W];
  logic [PIX_W-1:0]        ram1_q [IMG_W];
  logic [8:0][PIX_W-1:0]   win_q;
  logic [1:0]              vld_pipe_q;   // [0] window valid, [1] output valid
  logic [AW-1:0]           addr_q;
  logic [PIX_W-1:0]        data_q;
  logic                    done_q;

  logic             adv, acc, sof_acc, done, win_ok, last_px;
  logic [CW-1:0]    wcol;
  logic [PIX_W-1:0] top_px, mid_px, mag;

  // Everything advances only when the output register can take a new value.
  assign adv     = !vld_pipe_q[1] || out_rdy;
  assign acc     = in_val && in_rdy;
  assign sof_acc = acc && in_sof;
  assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign done    = (state_q == FLUSH) && vld_pipe_q[1] && out_rdy && !vld_pipe_q[0];
  assign win_ok  = acc && !in_sof && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign wcol    = in_sof ? '0 : col_q;

  // ram[sel] holds row r-2 and is overwritten with row r; ram[!sel] holds row r-1.
  assign top_px = sel_q ? ram1_q[col_q] : ram0_q[col_q];
  assign mid_px = sel_q ? ram0_q[col_q] : ram1_q[col_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (acc && !in_sof && row_q == RW'(2) && col_q == CW'(1)) state_d = RUN;
      RUN:     if (sof_acc) state_d = FILL;
               else if (acc && last_px) state_d = FLUSH;
      FLUSH:   if (done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_rdy = adv && (state_q != FLUSH);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (done) begin
      col_d = '0;
      row_d = '0;
    end else if (sof_acc) begin
      col_d = CW'(1);
      row_d = '0;
    end else if (acc) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        sel_d = ~sel_q;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    // A window already in flight at resync still takes its old address.
    if (done || sof_acc)            cnt_d = '0;
    else if (adv && vld_pipe_q[0])  cnt_d = cnt_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      if (sel_q) ram1_q[wcol] <= in_data;
      else       ram0_q[wcol] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q      <= '0;
      row_q      <= '0;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      win_q      <= '0;
      vld_pipe_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      done_q <= done;
      if (acc) begin
        win_q[0] <= win_q[1];  win_q[1] <= win_q[2];  win_q[2] <= top_px;
        win_q[3] <= win_q[4];  win_q[4] <= win_q[5];  win_q[5] <= mid_px;
        win_q[6] <= win_q[7];  win_q[7] <= win_q[8];  win_q[8] <= in_data;
      end
      if (adv) begin
        vld_pipe_q <= {vld_pipe_q[0], win_ok};
        if (vld_pipe_q[0]) begin
          data_q <= mag;
          addr_q <= cnt_q;
        end
      end
      if (done) addr_q <= '0;
    end
  end

  sobel_kernel #(.PIX_W(PIX_W), .THRESH(THRESH)) u_kernel (
    .p0_i (win_q[0]), .p1_i (win_q[1]), .p2_i (win_q[2]),
    .p3_i (win_q[3]), .p5_i (win_q[5]),
    .p6_i (win_q[6]), .p7_i (win_q[7]), .p8_i (win_q[8]),
    .mag_o(mag)
  );

  assign out_val    = vld_pipe_q[1];
  assign out_data   = data_q;
  assign out_addr   = addr_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Directed bench for sobel_stream_engine on an 8x6 frame.
module tb_sobel_stream_engine;
  localparam int W = 8, H = 6, NOUT = 24, AW = 5;

  logic           clk = 1'b0, reset = 1'b0, in_val = 1'b0, in_sof = 1'b0, out_rdy = 1'b1;
  logic [7:0]     in_data = '0;
  logic           in_rdy, out_val, frame_done;
  logic [7:0]     out_data;
  logic [AW-1:0]  out_addr;

  sobel_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .THRESH(128)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_val(in_val), .in_sof(in_sof),
    .in_rdy(in_rdy), .out_data(out_data), .out_addr(out_addr), .out_val(out_val),
    .out_rdy(out_rdy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: samples mid-cycle, records accepted outputs and events.
  logic [7:0] gd[$];
  int         ga[$];
  int         done_at[$];
  int         rise_q[$];
  int         done_cnt = 0, stall_cnt = 0, stall_bad = 0;
  logic       ov_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (out_val && out_rdy) begin
        gd.push_back(out_data);
        ga.push_back(int'(out_addr));
      end
      if (out_val && !out_rdy) begin
        stall_cnt <= stall_cnt + 1;
        if (in_rdy) stall_bad <= stall_bad + 1;
      end
      if (out_val && !ov_prev) rise_q.push_back(cyc);
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        done_at.push_back(gd.size());
      end
    end
    ov_prev <= out_val;
  end

  int rdy_mode = 0;
  int pat[4];
  initial begin
    pat = '{1, 0, 0, 1};
    forever begin
      @(posedge clk); #1;
      out_rdy = (rdy_mode == 0) || (pat[cyc % 4] != 0);
    end
  end

  typedef struct {
    int                mode;   // 0 flat 77, 1 vertical step, 2 horizontal step
    int                rdy;    // 0 always ready, 1 toggling 1,0,0,1
    logic [5:0][9:0]   ecol;   // expected contribution per output column
    logic [3:0][9:0]   erow;   // expected contribution per output row
  } vec_t;
  vec_t vecs[4];

  int tests = 0, fails = 0, acc22 = 0;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    case (mode)
      1:       return (c >= 4) ? 8'd100 : 8'd0;
      2:       return (r >= 3) ? 8'd20 : 8'd0;
      default: return 8'd77;
    endcase
  endfunction

  function automatic int exp_pix(input int v, input int i);
    int s;
    s = int'(vecs[v].ecol[i % 6]) + int'(vecs[v].erow[i / 6]);
    if (s > 255) s = 255;
`ifdef SOBEL_THRESH_EN
    s = (s >= 128) ? 255 : 0;
`endif
    return s;
  endfunction

  task automatic send(input int mode, input bit first_sof, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      in_data = pix(mode, i / W, i % W);
      in_val  = 1'b1;
      in_sof  = first_sof && (i == 0);
      k = 0;
      @(negedge clk);
      while (!in_rdy && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) chk("accept_timeout", k, 0);
      if (i == 2 * W + 2) acc22 = cyc;
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic wait_done(input int dbase);
    int k;
    k = 0;
    while (done_cnt == dbase && k < 300) begin @(negedge clk); k++; end
    chk("done_seen", int'(done_cnt > dbase), 1);
    repeat (4) @(negedge clk);
    chk("idle_out_val", int'(out_val), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string tag, input int v, input int base, input int dbase, input int dexp_pos);
    int r;
    chk({tag, "_count"}, gd.size() - base, NOUT);
    for (int i = 0; i < NOUT; i++) begin
      if (base + i < gd.size()) begin
        chk($sformatf("%s_data%0d", tag, i), int'(gd[base + i]), exp_pix(v, i));
        chk($sformatf("%s_addr%0d", tag, i), ga[base + i], i);
      end
    end
    chk({tag, "_done_count"}, done_cnt - dbase, 1);
    if (done_cnt > dbase) chk({tag, "_done_pos"}, done_at[dbase], dexp_pos);
    r = -1;
    foreach (rise_q[j]) if (r < 0 && rise_q[j] >= acc22) r = rise_q[j];
    chk({tag, "_latency"}, r - acc22, 2);
  endtask

  initial begin
    int base, dbase, sb, sc, k;
    vecs[0] = '{mode: 0, rdy: 0, ecol: {10'd0, 10'd0, 10'd0,   10'd0,   10'd0, 10'd0}, erow: {10'd0, 10'd0,  10'd0,  10'd0}};
    vecs[1] = '{mode: 1, rdy: 0, ecol: {10'd0, 10'd0, 10'd255, 10'd255, 10'd0, 10'd0}, erow: {10'd0, 10'd0,  10'd0,  10'd0}};
    vecs[2] = '{mode: 1, rdy: 1, ecol: {10'd0, 10'd0, 10'd255, 10'd255, 10'd0, 10'd0}, erow: {10'd0, 10'd0,  10'd0,  10'd0}};
    vecs[3] = '{mode: 2, rdy: 0, ecol: {10'd0, 10'd0, 10'd0,   10'd0,   10'd0, 10'd0}, erow: {10'd0, 10'd80, 10'd80, 10'd0}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_val",    int'(out_val),    0);
    chk("rst_out_data",   int'(out_data),   0);
    chk("rst_out_addr",   int'(out_addr),   0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_in_rdy",     int'(in_rdy),     1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      rdy_mode = vecs[v].rdy;
      base = gd.size(); dbase = done_cnt; sb = stall_bad; sc = stall_cnt;
      send(vecs[v].mode, 1'b1, W * H);
      wait_done(dbase);
      check_frame($sformatf("vec%0d", v), v, base, dbase, base + NOUT);
      chk($sformatf("vec%0d_stall_in_rdy", v), stall_bad - sb, 0);
      if (vecs[v].rdy != 0) chk($sformatf("vec%0d_stalls_seen", v), int'(stall_cnt > sc), 1);
    end
    rdy_mode = 0;

    // Resync: abort a flat frame at (3,5), then a clean horizontal-step frame.
    base = gd.size(); dbase = done_cnt;
    send(0, 1'b1, 3 * W + 5);
    send(2, 1'b1, W * H);
    wait_done(dbase);
    chk("sof_total", gd.size() - base, 9 + NOUT);
    for (int i = 0; i < 9; i++) begin
      if (base + i < gd.size()) begin
        chk($sformatf("sof_abort_data%0d", i), int'(gd[base + i]), 0);
        chk($sformatf("sof_abort_addr%0d", i), ga[base + i], i);
      end
    end
    check_frame("sof_clean", 3, base + 9, dbase, base + 9 + NOUT);

    // Reset mid-frame while an output is pending.
    send(0, 1'b1, 4 * W + 3);
    k = 0;
    @(negedge clk);
    while (!out_val && k < 20) begin @(negedge clk); k++; end
    chk("rstmid_pre_out_val", int'(out_val), 1);
    reset = 1'b0;
    #1;
    chk("rstmid_out_val", int'(out_val), 0);
    chk("rstmid_in_rdy",  int'(in_rdy),  1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    base = gd.size(); dbase = done_cnt;
    send(0, 1'b0, W * H);
    wait_done(dbase);
    check_frame("rstmid", 0, base, dbase, base + NOUT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
